// File: rtl/stack_seq.sv
// Stack command sequencer: decodes one stack op per 4-cycle pass and drives
// single-cycle push/pop strobes toward an external stack, tracking its depth.
module stack_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [34:0] cmd_imm,
    output logic        st__push,
    output logic [10:0] st__to_pop,
    output logic [34:0] st__to_push,
    input  logic [34:0] st__top_0,
    input  logic [34:0] st__top_1,
    input  logic        err_clr,
    output logic        err,
    output logic [11:0] depth
);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT1, WAIT2} state_t;

    localparam logic [3:0]  OP_NOP  = 4'd0;
    localparam logic [3:0]  OP_PUSH = 4'd1;
    localparam logic [3:0]  OP_DROP = 4'd2;
    localparam logic [3:0]  OP_DUP  = 4'd3;
    localparam logic [3:0]  OP_ADD  = 4'd4;
    localparam logic [3:0]  OP_SUB  = 4'd5;
    localparam logic [3:0]  OP_AND  = 4'd6;
    localparam logic [3:0]  OP_OR   = 4'd7;
    localparam logic [3:0]  OP_XOR  = 4'd8;
    localparam logic [3:0]  OP_OVER = 4'd9;
    localparam logic [11:0] MAX_DEPTH = 12'd2047;

    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic [11:0] depth_q, depth_d;
    logic        push_q, push_d;
    logic [10:0] to_pop_q, to_pop_d;
    logic [34:0] to_push_q, to_push_d;

    logic        accept;
    logic        dec_push;
    logic [10:0] dec_pop;
    logic [34:0] dec_val;
    logic [1:0]  need;
    logic        grows;
    logic        illegal;
    logic        bad;
    logic [11:0] depth_after;

    assign cmd_ready = (state_q == IDLE) && !err_q;
    assign accept    = cmd_valid && cmd_ready;

    // Opcode decode: a = top of stack, b = entry beneath it.
    always_comb begin
        dec_push = 1'b0;
        dec_pop  = 11'd0;
        dec_val  = 35'd0;
        need     = 2'd0;
        grows    = 1'b0;
        illegal  = 1'b0;
        case (cmd_op)
            OP_NOP: ;
            OP_PUSH: begin dec_push = 1'b1; dec_val = cmd_imm; grows = 1'b1; end
            OP_DROP: begin dec_pop = 11'd1; need = 2'd1; end
            OP_DUP:  begin dec_push = 1'b1; dec_val = st__top_0; need = 2'd1; grows = 1'b1; end
            OP_ADD:  begin dec_push = 1'b1; dec_pop = 11'd2; need = 2'd2; dec_val = st__top_1 + st__top_0; end
            OP_SUB:  begin dec_push = 1'b1; dec_pop = 11'd2; need = 2'd2; dec_val = st__top_1 - st__top_0; end
            OP_AND:  begin dec_push = 1'b1; dec_pop = 11'd2; need = 2'd2; dec_val = st__top_1 & st__top_0; end
            OP_OR:   begin dec_push = 1'b1; dec_pop = 11'd2; need = 2'd2; dec_val = st__top_1 | st__top_0; end
            OP_XOR:  begin dec_push = 1'b1; dec_pop = 11'd2; need = 2'd2; dec_val = st__top_1 ^ st__top_0; end
            OP_OVER: begin dec_push = 1'b1; dec_val = st__top_1; need = 2'd2; grows = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

    assign bad         = illegal || (depth_q < {10'd0, need}) || (grows && depth_q == MAX_DEPTH);
    assign depth_after = depth_q + {11'd0, dec_push} - {1'b0, dec_pop};

    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        push_d    = 1'b0;
        to_pop_d  = 11'd0;
        to_push_d = 35'd0;
        err_d     = (err_q && !err_clr) || (accept && bad);
        case (state_q)
            IDLE:  if (accept) state_d = DRIVE;
            DRIVE: state_d = WAIT1;
            WAIT1: state_d = WAIT2;
            WAIT2: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Faulting commands still occupy a pass but leave strobes and depth untouched.
        if (accept && !bad) begin
            push_d    = dec_push;
            to_pop_d  = dec_pop;
            to_push_d = dec_val;
            depth_d   = depth_after;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            depth_q   <= 12'd0;
            push_q    <= 1'b0;
            to_pop_q  <= 11'd0;
            to_push_q <= 35'd0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            depth_q   <= depth_d;
            push_q    <= push_d;
            to_pop_q  <= to_pop_d;
            to_push_q <= to_push_d;
        end
    end

    assign st__push    = push_q;
    assign st__to_pop  = to_pop_q;
    assign st__to_push = to_push_q;
    assign err         = err_q;
    assign depth       = depth_q;

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: a behavioural stack device answers the
// strobes, and a queue-based model predicts strobes, err and depth per command.
module tb_stack_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [34:0] cmd_imm;
    logic        st__push;
    logic [10:0] st__to_pop;
    logic [34:0] st__to_push;
    logic [34:0] st__top_0;
    logic [34:0] st__top_1;
    logic        err_clr;
    logic        err;
    logic [11:0] depth;

    int checks = 0;
    int failures = 0;

    stack_seq dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_imm(cmd_imm), .st__push(st__push),
        .st__to_pop(st__to_pop), .st__to_push(st__to_push),
        .st__top_0(st__top_0), .st__top_1(st__top_1),
        .err_clr(err_clr), .err(err), .depth(depth)
    );

    always #5 clk = ~clk;

    // Stack device driven purely by the DUT strobes.
    logic [34:0] dev_mem [0:2047];
    int dev_sp = 0;

    always @(posedge clk) begin
        if (rst) begin
            dev_sp <= 0;
        end else if (st__push) begin
            dev_mem[dev_sp - int'(st__to_pop)] <= st__to_push;
            dev_sp <= dev_sp - int'(st__to_pop) + 1;
        end else begin
            dev_sp <= dev_sp - int'(st__to_pop);
        end
    end

    assign st__top_0 = (dev_sp >= 1 && dev_sp <= 2048) ? dev_mem[dev_sp-1] : 35'd0;
    assign st__top_1 = (dev_sp >= 2 && dev_sp <= 2048) ? dev_mem[dev_sp-2] : 35'd0;

    // Reference model: the stack contents as the specification defines them.
    logic [34:0] mq[$];

    task automatic model_cmd(input logic [3:0] op, input logic [34:0] imm,
                             output bit e_push, output int e_pop,
                             output logic [34:0] e_val, output bit e_err);
        int n;
        logic [34:0] a, b, r;
        n = mq.size();
        a = (n >= 1) ? mq[n-1] : 35'd0;
        b = (n >= 2) ? mq[n-2] : 35'd0;
        e_push = 0; e_pop = 0; e_val = 35'd0; e_err = 0;
        case (op)
            4'd0: ;
            4'd1: if (n == 2047) e_err = 1; else begin e_push = 1; e_val = imm; mq.push_back(imm); end
            4'd2: if (n < 1) e_err = 1; else begin e_pop = 1; void'(mq.pop_back()); end
            4'd3: if (n < 1 || n == 2047) e_err = 1; else begin e_push = 1; e_val = a; mq.push_back(a); end
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                if (n < 2) e_err = 1;
                else begin
                    case (op)
                        4'd4: r = b + a;
                        4'd5: r = b - a;
                        4'd6: r = b & a;
                        4'd7: r = b | a;
                        default: r = b ^ a;
                    endcase
                    void'(mq.pop_back());
                    void'(mq.pop_back());
                    mq.push_back(r);
                    e_push = 1; e_pop = 2; e_val = r;
                end
            end
            4'd9: if (n < 2 || n == 2047) e_err = 1; else begin e_push = 1; e_val = b; mq.push_back(b); end
            default: e_err = 1;
        endcase
    endtask

    // Waits for cmd_ready, offers one command, returns 1 time unit after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [34:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL ready_timeout got=%0b exp=1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd1; cmd_imm = 35'h1234; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (st__push !== 1'b0) begin failures++; $display("FAIL reset_push got=%0b exp=0", st__push); end
        checks++; if (depth !== 12'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        checks++; if (st__to_push !== 35'd0) begin failures++; $display("FAIL reset_to_push got=%h exp=0", st__to_push); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        $display("test_reset done");
    endtask

    task automatic test_push_sub;
        bit ep; int epop; logic [34:0] ev; bit ee;
        logic [34:0] vals [3];
        logic [3:0]  ops  [3];
        logic [34:0] exp_v[3];
        int          exp_p[3];
        int          exp_d[3];
        vals = '{35'd5, 35'd7, 35'd0};
        ops  = '{4'd1, 4'd1, 4'd5};
        exp_v = '{35'd5, 35'd7, 35'h7FFFFFFFE};
        exp_p = '{0, 0, 2};
        exp_d = '{1, 2, 1};
        for (int i = 0; i < 3; i++) begin
            model_cmd(ops[i], vals[i], ep, epop, ev, ee);
            issue(ops[i], vals[i]);
            checks++; if (st__push !== 1'b1) begin failures++; $display("FAIL ps_push[%0d] got=%0b exp=1", i, st__push); end
            checks++; if (st__to_pop !== 11'(exp_p[i])) begin failures++; $display("FAIL ps_pop[%0d] got=%0d exp=%0d", i, st__to_pop, exp_p[i]); end
            checks++; if (st__to_push !== exp_v[i]) begin failures++; $display("FAIL ps_val[%0d] got=%h exp=%h", i, st__to_push, exp_v[i]); end
            checks++; if (depth !== 12'(exp_d[i])) begin failures++; $display("FAIL ps_depth[%0d] got=%0d exp=%0d", i, depth, exp_d[i]); end
            checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ps_ready_c0[%0d] got=%0b exp=0", i, cmd_ready); end
            for (int k = 1; k <= 3; k++) begin
                @(posedge clk);
                #1;
                checks++;
                if (cmd_ready !== (k == 3)) begin failures++; $display("FAIL ps_ready_c%0d[%0d] got=%0b exp=%0b", k, i, cmd_ready, k == 3); end
                if (k == 1) begin
                    checks++; if (st__push !== 1'b0) begin failures++; $display("FAIL ps_strobe_len[%0d] got=%0b exp=0", i, st__push); end
                end
            end
            $display("cmd op=%0d imm=%h push=%0b pop=%0d val=%h depth=%0d", ops[i], vals[i], ep, epop, ev, mq.size());
        end
    endtask

    task automatic test_underflow;
        bit ep; int epop; logic [34:0] ev; bit ee;
        bit ready_seen;
        model_cmd(4'd2, 35'd0, ep, epop, ev, ee);
        issue(4'd2, 35'd0);
        model_cmd(4'd2, 35'd0, ep, epop, ev, ee);
        issue(4'd2, 35'd0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL uf_err got=%0b exp=1", err); end
        checks++; if (st__push !== 1'b0 || st__to_pop !== 11'd0) begin failures++; $display("FAIL uf_strobe got=%0b/%0d exp=0/0", st__push, st__to_pop); end
        checks++; if (depth !== 12'd0) begin failures++; $display("FAIL uf_depth got=%0d exp=0", depth); end
        ready_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (cmd_ready) ready_seen = 1;
        end
        checks++; if (ready_seen) begin failures++; $display("FAIL uf_ready_held got=1 exp=0"); end
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL uf_clr got=%0b exp=0", err); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL uf_ready_back got=%0b exp=1", cmd_ready); end
        $display("test_underflow done depth=%0d", mq.size());
    endtask

    task automatic test_illegal;
        bit ep; int epop; logic [34:0] ev; bit ee;
        model_cmd(4'd1, 35'h55, ep, epop, ev, ee);
        issue(4'd1, 35'h55);
        model_cmd(4'd12, 35'h3, ep, epop, ev, ee);
        issue(4'd12, 35'h3);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err got=%0b exp=1", err); end
        checks++; if (st__push !== 1'b0 || st__to_pop !== 11'd0 || st__to_push !== 35'd0)
            begin failures++; $display("FAIL ill_outs got=%0b/%0d/%h exp=0/0/0", st__push, st__to_pop, st__to_push); end
        checks++; if (depth !== 12'd1) begin failures++; $display("FAIL ill_depth got=%0d exp=1", depth); end
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_clr got=%0b exp=0", err); end
        $display("test_illegal done");
    endtask

    task automatic test_random;
        bit ep; int epop; logic [34:0] ev; bit ee;
        logic [3:0] op;
        logic [34:0] imm;
        int r;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if (r < 6) op = 4'd1;
            else if (r == 19) op = 4'($urandom_range(10, 15));
            else op = 4'($urandom_range(0, 9));
            imm = 35'({$urandom(), $urandom()});
            model_cmd(op, imm, ep, epop, ev, ee);
            issue(op, imm);
            checks++; if (st__push !== ep) begin failures++; $display("FAIL rnd_push[%0d] op=%0d got=%0b exp=%0b", i, op, st__push, ep); end
            checks++; if (st__to_pop !== 11'(epop)) begin failures++; $display("FAIL rnd_pop[%0d] op=%0d got=%0d exp=%0d", i, op, st__to_pop, epop); end
            checks++; if (st__to_push !== ev) begin failures++; $display("FAIL rnd_val[%0d] op=%0d got=%h exp=%h", i, op, st__to_push, ev); end
            checks++; if (err !== ee) begin failures++; $display("FAIL rnd_err[%0d] op=%0d got=%0b exp=%0b", i, op, err, ee); end
            checks++; if (depth !== 12'(mq.size())) begin failures++; $display("FAIL rnd_depth[%0d] op=%0d got=%0d exp=%0d", i, op, depth, mq.size()); end
            $display("cmd op=%0d imm=%h push=%0b pop=%0d val=%h err=%0b depth=%0d", op, imm, ep, epop, ev, ee, mq.size());
            if (ee) begin
                @(negedge clk); err_clr = 1'b1;
                @(posedge clk); #1; err_clr = 1'b0;
                checks++; if (err !== 1'b0) begin failures++; $display("FAIL rnd_clr[%0d] got=%0b exp=0", i, err); end
            end
        end
    endtask

    task automatic test_overflow;
        bit ep; int epop; logic [34:0] ev; bit ee;
        logic [34:0] imm;
        while (mq.size() < 2047) begin
            imm = 35'($urandom());
            model_cmd(4'd1, imm, ep, epop, ev, ee);
            issue(4'd1, imm);
        end
        checks++; if (depth !== 12'd2047) begin failures++; $display("FAIL of_full got=%0d exp=2047", depth); end
        model_cmd(4'd3, 35'd0, ep, epop, ev, ee);
        issue(4'd3, 35'd0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL of_err got=%0b exp=1", err); end
        checks++; if (st__push !== 1'b0) begin failures++; $display("FAIL of_push got=%0b exp=0", st__push); end
        checks++; if (depth !== 12'd2047) begin failures++; $display("FAIL of_depth got=%0d exp=2047", depth); end
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        model_cmd(4'd4, 35'd0, ep, epop, ev, ee);
        issue(4'd4, 35'd0);
        checks++; if (st__push !== 1'b1 || st__to_push !== ev) begin failures++; $display("FAIL of_add got=%0b/%h exp=1/%h", st__push, st__to_push, ev); end
        checks++; if (depth !== 12'd2046) begin failures++; $display("FAIL of_add_depth got=%0d exp=2046", depth); end
        $display("test_overflow done depth=%0d", mq.size());
    endtask

    task automatic test_reset_mid;
        issue(4'd1, 35'h4AA);
        checks++; if (st__push !== 1'b1) begin failures++; $display("FAIL rm_pre_push got=%0b exp=1", st__push); end
        #1 rst = 1'b1;
        #1;
        checks++; if (st__push !== 1'b0) begin failures++; $display("FAIL rm_async_push got=%0b exp=0", st__push); end
        checks++; if (st__to_push !== 35'd0) begin failures++; $display("FAIL rm_async_val got=%h exp=0", st__to_push); end
        checks++; if (depth !== 12'd0) begin failures++; $display("FAIL rm_depth got=%0d exp=0", depth); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rm_err got=%0b exp=0", err); end
        mq.delete();
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_imm = 35'h123;
        @(posedge clk); #1;
        checks++; if (st__push !== 1'b0) begin failures++; $display("FAIL rm_valid_ignored got=%0b exp=0", st__push); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        mq.push_back(35'h123);
        checks++; if (st__push !== 1'b1 || st__to_push !== 35'h123) begin failures++; $display("FAIL rm_first_accept got=%0b/%h exp=1/123", st__push, st__to_push); end
        checks++; if (depth !== 12'd1) begin failures++; $display("FAIL rm_first_depth got=%0d exp=1", depth); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_push_sub();
        test_underflow();
        test_illegal();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: cmd_valid  input  1  command offered this cycle.
REQ-004: cmd_ready  output  1  sequencer accepts a command; equals (state==IDLE && !err).
REQ-005: cmd_op  input  4  opcode: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 OVER; 10-15 illegal.
REQ-006: cmd_imm  input  35  PUSH immediate.
REQ-007: st__push  output  1  push strobe to stack.
REQ-008: st__to_pop  output  11  entries popped by stack.
REQ-009: st__to_push  output  35  value pushed.
REQ-010: st__top_0  input  35  registered top-of-stack from stack.
REQ-011: st__top_1  input  35  registered second entry from stack.
REQ-012: err_clr  input  1  clears err.
REQ-013: err  output  1  sticky underflow/overflow/illegal-op flag.
REQ-014: depth  output  12  entries currently on stack, 0..2047.

Function
REQ-015: FSM states IDLE, DRIVE, WAIT1, WAIT2; IDLE->DRIVE on accept (cmd_valid && cmd_ready); DRIVE->WAIT1->WAIT2->IDLE unconditionally.
REQ-016: Throughput one command per 4 cycles; next accept no earlier than 3 cycles after the previous accept edge, so st__top_0/1 reflect the prior op when sampled.
REQ-017: st__push, st__to_pop, st__to_push are registered at the accept edge and held for exactly the DRIVE cycle; zero in all other states.
REQ-018: Result operands are sampled from st__top_0 (a) and st__top_1 (b) at the accept edge.
REQ-019: NOP: push=0, pop=0; depth unchanged.
REQ-020: PUSH: push=1, pop=0, to_push=cmd_imm; depth+1.
REQ-021: DROP: push=0, pop=1; depth-1.
REQ-022: DUP: push=1, pop=0, to_push=a; depth+1.
REQ-023: OVER: push=1, pop=0, to_push=b; depth+1.
REQ-024: ADD/SUB/AND/OR/XOR: push=1, pop=2, to_push = b+a, b-a, b&a, b|a, b^a; depth-1.
REQ-025: Arithmetic is modulo 2^35; carry/borrow discarded.
REQ-026: Underflow: DROP/DUP with depth<1, or binary/OVER with depth<2.
REQ-027: Overflow: PUSH/DUP/OVER with depth==2047.
REQ-028: On underflow, overflow, or illegal opcode: command consumed, DRIVE outputs all zero, depth unchanged, err set at the accept edge.
REQ-029: While err=1, cmd_ready=0; FSM still completes its current pass to IDLE.
REQ-030: err_clr clears err on the next edge; if err_clr and a new error coincide, err stays 1.
REQ-031: depth updates at the accept edge.

Reset
REQ-032: While rst is high: state=IDLE, err=0, depth=0, st__push=0, st__to_pop=0, st__to_push=0; effective asynchronously.
REQ-033: Reset mid-command (DRIVE/WAIT*) aborts it; strobes drop immediately and the command is discarded.
REQ-034: cmd_valid is ignored while rst is high; the first accept is possible on the first edge after release.

Verification
REQ-035: After reset, PUSH 5 then PUSH 7 -> two DRIVE pulses, push=1, pop=0, to_push 5 then 7; depth=2; cmd_ready low 3 cycles after each accept.
REQ-036: Stack holds 7 (a) over 5 (b), SUB -> DRIVE push=1, pop=2, to_push=0x7FFFFFFFE (5-7 mod 2^35); depth=1.
REQ-037: depth=0, DROP -> no strobe, err=1, cmd_ready stays 0; err_clr pulse -> err=0, cmd_ready=1 at next IDLE.
REQ-038: 2047 PUSHes then DUP -> err=1, depth stays 2047, no strobe.
REQ-039: opcode 12 -> err=1, all DRIVE outputs zero.
REQ-040: rst asserted during DRIVE of PUSH -> st__push drops asynchronously, depth=0, err=0.
